// File: rtl/controlador_if.sv
// Board-side bundle for the ALU controller: switch data, load strobes and result.
// master drives switches/strobes (board or bench); slave is the controller.
interface controlador_if #(
  parameter int NB_DATA      = 8,
  parameter int N_PULSADORES = 3
);
  logic [NB_DATA-1:0]      i_switches;
  logic [N_PULSADORES-1:0] i_pulsadores;
  logic [NB_DATA-1:0]      o_result;

  modport master (
    output i_switches,
    output i_pulsadores,
    input  o_result
  );

  modport slave (
    input  i_switches,
    input  i_pulsadores,
    output o_result
  );
endinterface

// File: rtl/controlador.sv
// ALU controller: push-buttons latch operands A/B and the opcode from the switches.
// Latency: result is combinational from the registers, valid right after the loading edge.
// No backpressure: strobes are level loads, every rising edge with a strobe high captures.
module controlador #(
  parameter int NB_DATA      = 8,
  parameter int NB_OPCODE    = 6,
  parameter int N_PULSADORES = 3
) (
  input  logic          i_clock,
  input  logic          i_reset,
  controlador_if.slave  bus
);

  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
  localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
  localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);

  logic [NB_DATA-1:0]   reg_a;
  logic [NB_DATA-1:0]   reg_b;
  logic [NB_OPCODE-1:0] reg_op;

  // Shift amount is the full-width B, so B >= NB_DATA saturates to 0 / sign fill.
  function automatic logic [NB_DATA-1:0] alu(
    input logic [NB_DATA-1:0]   a,
    input logic [NB_DATA-1:0]   b,
    input logic [NB_OPCODE-1:0] op
  );
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_NOR:  alu = ~(a | b);
      OP_SRA:  alu = NB_DATA'($signed(a) >>> b);
      OP_SRL:  alu = a >> b;
      default: alu = '0;
    endcase
  endfunction

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= '0;
    end else begin
      if (bus.i_pulsadores[0]) reg_a  <= bus.i_switches;
      if (bus.i_pulsadores[1]) reg_b  <= bus.i_switches;
      if (bus.i_pulsadores[2]) reg_op <= bus.i_switches[NB_OPCODE-1:0];
    end
  end

  assign bus.o_result = alu(reg_a, reg_b, reg_op);

endmodule

// File: tb/tb_controlador.sv
// Directed bench for controlador: stimulus pushes hand-computed results, a negedge monitor pops and compares.
module tb_controlador;

  logic i_clock;
  logic i_reset;

  controlador_if #(.NB_DATA(8), .N_PULSADORES(3)) bus ();

  controlador #(
    .NB_DATA      (8),
    .NB_OPCODE    (6),
    .N_PULSADORES (3)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  always @(negedge i_clock) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (bus.o_result !== e) begin
        bad++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", n, bus.o_result, e);
      end
    end
  end

  task automatic step(input logic [7:0] sw, input logic [2:0] pb);
    bus.i_switches   = sw;
    bus.i_pulsadores = pb;
    @(posedge i_clock);
    #1;
    bus.i_pulsadores = 3'b000;
  endtask

  task automatic expect_res(input string name, input logic [7:0] val);
    exp_q.push_back(val);
    name_q.push_back(name);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(negedge i_clock);
      #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: monitor timeout, %0d entries pending, expected 0", name, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    i_reset          = 1'b0;
    bus.i_switches   = 8'hFF;
    bus.i_pulsadores = 3'b111;
    repeat (3) @(posedge i_clock);
    #1;
    expect_res("reset_hold", 8'h00);

    bus.i_pulsadores = 3'b000;
    i_reset          = 1'b1;
    step(8'hAA, 3'b000);
    expect_res("post_reset", 8'h00);

    // ADD with wrap-around
    step(8'hF0, 3'b001);
    step(8'h20, 3'b010);
    step(8'h20, 3'b100);
    expect_res("add_wrap", 8'h10);

    // SUB negative, then NOR on the same operands
    step(8'h05, 3'b001);
    step(8'h07, 3'b010);
    step(8'h22, 3'b100);
    expect_res("sub_neg", 8'hFE);
    step(8'h27, 3'b100);
    expect_res("nor", 8'hF8);

    // Shifts by 2 and by more than the width
    step(8'hCC, 3'b001);
    step(8'h02, 3'b010);
    step(8'h03, 3'b100);
    expect_res("sra_2", 8'hF3);
    step(8'h02, 3'b100);
    expect_res("srl_2", 8'h33);
    step(8'h09, 3'b010);
    expect_res("srl_9", 8'h00);
    step(8'h03, 3'b100);
    expect_res("sra_9", 8'hFF);
    step(8'h00, 3'b010);
    expect_res("sra_0", 8'hCC);

    // Logic ops and opcode edge cases
    step(8'hAA, 3'b010);
    step(8'h24, 3'b100);
    expect_res("and", 8'h88);
    step(8'h25, 3'b100);
    expect_res("or", 8'hEE);
    step(8'h26, 3'b100);
    expect_res("xor", 8'h66);
    step(8'h3F, 3'b100);
    expect_res("undef_op", 8'h00);
    step(8'hE0, 3'b100);
    expect_res("op_high_bits_ignored", 8'h76);

    // Hold: strobes low while switches change
    step(8'h26, 3'b100);
    expect_res("xor_again", 8'h66);
    for (int i = 0; i < 10; i++) begin
      step(8'(i * 37 + 1), 3'b000);
      expect_res("hold", 8'h66);
    end

    // Simultaneous A/B load
    step(8'h03, 3'b011);
    step(8'h20, 3'b100);
    expect_res("simul_add", 8'h06);

    // All three strobes at once: A=B=0x24, op=AND
    step(8'h24, 3'b111);
    expect_res("all_strobes", 8'h24);

    // Asynchronous reset mid-sequence, between clock edges
    #2;
    i_reset = 1'b0;
    #1;
    expect_res("async_reset", 8'h00);
    i_reset = 1'b1;
    step(8'h55, 3'b000);
    expect_res("after_reset_hold", 8'h00);
    step(8'h20, 3'b100);
    expect_res("after_reset_add_zero", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
